// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - instruction memory with a byte-serial loader and a synchronous fetch port
// Bytes are packed into words in arrival order and written to consecutive addresses.
module inst_mem_loader #(
    parameter int ADDR_WIDTH     = 10,
    parameter int BYTES_PER_WORD = 4,
    parameter int BIG_ENDIAN     = 1
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic [ADDR_WIDTH-1:0]       pc,
    input  logic                        loader_enable,
    input  logic [7:0]                  loader_data,
    input  logic                        loader_ready,
    output logic [8*BYTES_PER_WORD-1:0] inst,
    output logic [ADDR_WIDTH:0]         loaded_words,
    output logic                        load_busy,
    output logic                        load_done,
    output logic                        overflow
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int WORD_W = 8*BYTES_PER_WORD;
    localparam int CNT_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES_PER_WORD-1);
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [WORD_W-1:0]     mem [DEPTH];
    logic [WORD_W-1:0]     asm_q, asm_next, asm_merged;
    logic [CNT_W-1:0]      cnt_q, cnt_next, lane;
    logic [ADDR_WIDTH:0]   lw_q, lw_next;
    logic                  ovf_q, ovf_next;
    logic                  mem_we;
    logic [WORD_W-1:0]     mem_wdata;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  full;

    // The write pointer is the word count itself; full memory stops writes instead of wrapping.
    assign wr_ptr = lw_q[ADDR_WIDTH-1:0];
    assign full   = (lw_q == FULL_CNT);

    always_comb begin
        lane = (BIG_ENDIAN != 0) ? (LAST - cnt_q) : cnt_q;
        asm_merged = asm_q;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (lane == CNT_W'(i)) begin
                asm_merged[i*8 +: 8] = loader_data;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt_q;
        asm_next   = asm_q;
        lw_next    = lw_q;
        ovf_next   = ovf_q;
        mem_we     = 1'b0;
        mem_wdata  = asm_merged;
        case (state)
            IDLE, DONE: begin
                if (loader_enable) begin
                    state_next = LOAD;
                    cnt_next   = '0;
                    asm_next   = '0;
                    lw_next    = '0;
                    ovf_next   = 1'b0;
                end
            end
            LOAD: begin
                if (loader_ready) begin
                    if (full) begin
                        ovf_next = 1'b1;
                    end else if (cnt_q == LAST) begin
                        mem_we   = 1'b1;
                        lw_next  = lw_q + 1'b1;
                        cnt_next = '0;
                        asm_next = '0;
                    end else begin
                        cnt_next = cnt_q + 1'b1;
                        asm_next = asm_merged;
                    end
                end
                // Decide on the post-acceptance count so a last byte arriving with enable low is honoured.
                if (!loader_enable) begin
                    state_next = (cnt_next != '0) ? FLUSH : DONE;
                end
            end
            FLUSH: begin
                mem_wdata = asm_q;
                if (full) begin
                    ovf_next = 1'b1;
                end else begin
                    mem_we  = 1'b1;
                    lw_next = lw_q + 1'b1;
                end
                cnt_next   = '0;
                asm_next   = '0;
                state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            cnt_q <= '0;
            asm_q <= '0;
            lw_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_next;
            asm_q <= asm_next;
            lw_q  <= lw_next;
            ovf_q <= ovf_next;
        end
    end

    // Array kept free of reset so it maps onto block RAM; reset only blocks writes.
    always_ff @(posedge CLK) begin
        if (mem_we && !reset) begin
            mem[wr_ptr] <= mem_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            inst <= '0;
        end else begin
            inst <= mem[pc];
        end
    end

    assign loaded_words = lw_q;
    assign load_busy    = (state == LOAD) || (state == FLUSH);
    assign load_done    = (state == DONE);
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - directed bench for inst_mem_loader, big- and little-endian builds side by side
module tb_inst_mem_loader;

    logic        CLK = 1'b0;
    logic        reset;
    logic [1:0]  pc;
    logic        loader_enable;
    logic [7:0]  loader_data;
    logic        loader_ready;
    logic [31:0] inst_be, inst_le;
    logic [2:0]  lw_be, lw_le;
    logic        busy_be, busy_le, done_be, done_le, ovf_be, ovf_le;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    inst_mem_loader #(.ADDR_WIDTH(2), .BYTES_PER_WORD(4), .BIG_ENDIAN(1)) dut_be (
        .CLK(CLK), .reset(reset), .pc(pc), .loader_enable(loader_enable),
        .loader_data(loader_data), .loader_ready(loader_ready), .inst(inst_be),
        .loaded_words(lw_be), .load_busy(busy_be), .load_done(done_be), .overflow(ovf_be)
    );

    inst_mem_loader #(.ADDR_WIDTH(2), .BYTES_PER_WORD(4), .BIG_ENDIAN(0)) dut_le (
        .CLK(CLK), .reset(reset), .pc(pc), .loader_enable(loader_enable),
        .loader_data(loader_data), .loader_ready(loader_ready), .inst(inst_le),
        .loaded_words(lw_le), .load_busy(busy_le), .load_done(done_le), .overflow(ovf_le)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic send(input logic [7:0] b);
        loader_ready = 1'b1;
        loader_data  = b;
        @(negedge CLK);
        loader_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        pc = '0;
        loader_enable = 1'b0;
        loader_data = '0;
        loader_ready = 1'b0;
        tick();
        tick();
        check("rst_inst", inst_be, 32'h0);
        check("rst_lw", 32'(lw_be), 32'd0);
        check("rst_busy", 32'(busy_be), 32'd0);
        check("rst_done", 32'(done_be), 32'd0);
        check("rst_ovf", 32'(ovf_be), 32'd0);

        // Two full words: AA x4 then FF FF 00 00
        reset = 1'b0;
        loader_enable = 1'b1;
        tick();
        check("load_busy", 32'(busy_be), 32'd1);
        for (int i = 0; i < 4; i++) send(8'hAA);
        send(8'hFF); send(8'hFF); send(8'h00); send(8'h00);
        loader_enable = 1'b0;
        tick();
        check("s1_done", 32'(done_be), 32'd1);
        check("s1_busy", 32'(busy_be), 32'd0);
        check("s1_lw", 32'(lw_be), 32'd2);
        pc = 2'd0;
        tick();
        check("s1_m0_be", inst_be, 32'hAAAAAAAA);
        check("s1_m0_le", inst_le, 32'hAAAAAAAA);
        pc = 2'd1;
        tick();
        check("s1_m1_be", inst_be, 32'hFFFF0000);
        check("s1_m1_le", inst_le, 32'h0000FFFF);

        // Partial word, last byte arrives as enable falls
        pc = 2'd0;
        loader_enable = 1'b1;
        tick();
        check("s2_lw_clr", 32'(lw_be), 32'd0);
        check("s2_done_clr", 32'(done_be), 32'd0);
        send(8'h12);
        loader_enable = 1'b0;
        send(8'h34);
        check("flush_busy", 32'(busy_be), 32'd1);
        check("flush_lw0", 32'(lw_be), 32'd0);
        tick();
        check("flush_busy_drop", 32'(busy_be), 32'd0);
        check("flush_done", 32'(done_be), 32'd1);
        check("flush_lw1", 32'(lw_be), 32'd1);
        tick();
        check("flush_m0_be", inst_be, 32'h12340000);
        check("flush_m0_le", inst_le, 32'h00003412);

        // Overflow: five words into four locations
        loader_enable = 1'b1;
        tick();
        for (int w = 1; w <= 4; w++)
            for (int b = 0; b < 4; b++) send(8'((w << 4) | b));
        check("ovf_lw_full", 32'(lw_be), 32'd4);
        check("ovf_pre", 32'(ovf_be), 32'd0);
        for (int b = 0; b < 4; b++) send(8'(8'h50 | b));
        check("ovf_set", 32'(ovf_be), 32'd1);
        check("ovf_lw_hold", 32'(lw_be), 32'd4);
        loader_enable = 1'b0;
        tick();
        check("ovf_done", 32'(done_be), 32'd1);
        check("ovf_sticky", 32'(ovf_be), 32'd1);
        pc = 2'd0;
        tick();
        check("ovf_m0_be", inst_be, 32'h10111213);
        pc = 2'd3;
        tick();
        check("ovf_m3_be", inst_be, 32'h40414243);
        check("ovf_m3_le", inst_le, 32'h43424140);

        // Reset in the middle of the second word
        loader_enable = 1'b1;
        tick();
        send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
        send(8'hB1); send(8'hB2);
        check("mid_lw", 32'(lw_be), 32'd1);
        reset = 1'b1;
        loader_enable = 1'b0;
        tick();
        check("mid_rst_inst", inst_be, 32'h0);
        check("mid_rst_lw", 32'(lw_be), 32'd0);
        check("mid_rst_busy", 32'(busy_be), 32'd0);
        check("mid_rst_done", 32'(done_be), 32'd0);
        check("mid_rst_ovf", 32'(ovf_be), 32'd0);
        reset = 1'b0;
        pc = 2'd0;
        tick();
        check("mid_m0_be", inst_be, 32'hA1A2A3A4);
        check("mid_m0_le", inst_le, 32'hA4A3A2A1);
        pc = 2'd1;
        tick();
        check("mid_m1_kept", inst_be, 32'h20212223);

        // Eight back-to-back bytes, reading address 1 while it is written
        loader_enable = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) send(8'(8'hC0 + i));
        check("b2b_lw1", 32'(lw_be), 32'd1);
        check("b2b_busy", 32'(busy_be), 32'd1);
        for (int i = 4; i < 8; i++) send(8'(8'hC0 + i));
        check("b2b_lw2", 32'(lw_be), 32'd2);
        check("b2b_readfirst", inst_be, 32'h20212223);
        tick();
        check("b2b_new_be", inst_be, 32'hC4C5C6C7);
        check("b2b_new_le", inst_le, 32'hC7C6C5C4);
        pc = 2'd0;
        tick();
        check("b2b_m0_be", inst_be, 32'hC0C1C2C3);
        loader_enable = 1'b0;
        tick();
        check("b2b_done", 32'(done_be), 32'd1);
        check("b2b_le_lw", 32'(lw_le), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Parametrised instruction memory with an integrated byte-serial loader; successor to the fixed 32-bit inst_memory.
- The loader assembles 8-bit bytes into words of configurable width and byte order, and writes them to sequential addresses.
- Tracks load progress and flags overflow.
- The core fetch stage reads instructions by pc through a synchronous read port.

Parameters:
- ADDR_WIDTH, 10, address bits; depth = 2**ADDR_WIDTH words.
- BYTES_PER_WORD, 4, bytes per instruction word; legal range 1..8.
- BIG_ENDIAN, 1, 1 = first received byte goes to the MSB; 0 = first byte goes to the LSB.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- pc  in  ADDR_WIDTH  fetch address.
- loader_enable  in  1  level; high = load session active.
- loader_data  in  8  byte from the external loader.
- loader_ready  in  1  one-cycle strobe; loader_data valid this cycle.
- inst  out  8*BYTES_PER_WORD  fetched word.
- loaded_words  out  ADDR_WIDTH+1  words written in the current/last session.
- load_busy  out  1  high while in LOAD or FLUSH.
- load_done  out  1  high after a session closes, until the next session starts.
- overflow  out  1  sticky; a byte arrived after memory was full.

Behaviour:
- Reset values:
  - inst=0, loaded_words=0, load_busy=0, load_done=0, overflow=0.
  - State IDLE; byte counter and write pointer cleared.
  - Memory array is NOT cleared.
- Read port:
  - inst <= mem[pc] every cycle, independent of loader state; latency 1 cycle.
  - Same-cycle write to the addressed word returns the old data (read-first).
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE:
  - loader_enable=1 moves to LOAD.
  - On entry to LOAD: byte counter, write pointer and loaded_words reset to 0; overflow and load_done cleared.
- LOAD:
  - Each cycle with loader_ready=1, place loader_data into the assembly register lane selected by the byte counter and BIG_ENDIAN.
  - Byte counter increments on each accepted byte.
  - On the BYTES_PER_WORD-th byte, the word (including that byte) is written to mem[wr_ptr] on the same edge.
  - After the write: wr_ptr+1, loaded_words+1, byte counter returns to 0.
  - loader_ready while loaded_words == 2**ADDR_WIDTH: byte dropped, overflow <= 1, no memory write, pointer does not wrap.
  - loader_enable=0 with byte counter > 0 moves to FLUSH; with byte counter = 0 moves directly to DONE.
  - A loader_ready in the same cycle as loader_enable falling is still accepted.
- FLUSH (one cycle):
  - Unreceived lanes are zero-filled and the partial word is written to mem[wr_ptr].
  - loaded_words+1, then go to DONE.
  - If memory is full: no write, overflow <= 1.
- DONE:
  - load_done=1; loaded_words holds its value.
  - loader_enable=1 starts a new session (LOAD with counters cleared).
- load_busy = 1 in LOAD and FLUSH.
- Multi-byte arrival: loader_ready on consecutive cycles is legal; one byte is accepted per cycle.
- Reset mid-session:
  - Aborts the session immediately and returns to IDLE.
  - A partially assembled word is discarded.
  - Words already written remain in memory.
- loaded_words width ADDR_WIDTH+1 so a full memory (2**ADDR_WIDTH) is representable.

Test Plan:
- ADDR_WIDTH=2, BPW=4, BIG_ENDIAN=1: enable, 4x loader_ready with AA, disable; pc=0 -> inst=32'hAAAAAAAA one cycle after pc is applied, loaded_words=1, load_done=1.
- Same config: bytes FF,FF,00,00 as the second word -> mem[1]=32'hFFFF0000. Rebuild with BIG_ENDIAN=0 -> 32'h0000FFFF.
- Partial flush: bytes 12,34 then loader_enable falls -> FLUSH writes 32'h12340000, loaded_words increments, load_busy drops after one cycle.
- Overflow: 5 full words into depth 4 -> mem[0..3] hold words 1-4, 5th word dropped, overflow=1, loaded_words=4.
- Reset after 2 bytes of word 2 (word 1 complete) -> state IDLE, all outputs 0, mem[0] retains word 1. New session rewrites from address 0.
- Back-to-back: loader_ready high for 8 consecutive cycles -> two words written on cycles 4 and 8. Read of the address being written returns the old value for that cycle, the new value next cycle.
